// File: rtl/instr_fetch.sv
// Instruction fetch front end: one outstanding memory read, a 2-deep {instr, pc}
// queue to decode, branch redirect with response discard, and halt on op 4'hF.
module instr_fetch #(
  parameter int unsigned    AW       = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [15:0]   if_instr,
  output logic [AW-1:0] if_pc,
  output logic          if_illegal,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          halted
);

  // state   | meaning
  // S_FETCH | no request outstanding; issue one when the queue has room
  // S_WAIT  | request outstanding; hold req/addr until imem_ack
  // S_HALT  | halt opcode queued; no further fetches until a redirect
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          disc_q, disc_d;
  logic          run_q, run_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [15:0]   instr_q [2];
  logic [15:0]   instr_d [2];
  logic [AW-1:0] qpc_q [2];
  logic [AW-1:0] qpc_d [2];

  logic pop;
  logic accept;
  logic push;
  logic wr_hi;
  logic op_legal;

  assign if_valid = (cnt_q != 2'd0);
  assign if_instr = instr_q[0];
  assign if_pc    = qpc_q[0];
  assign halted   = (state_q == S_HALT) && (cnt_q == 2'd0);

  always_comb begin
    unique case (if_instr[15:12])
      4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'hA, 4'hE, 4'hF: op_legal = 1'b1;
      default:                                              op_legal = 1'b0;
    endcase
  end

  assign if_illegal = if_valid && !op_legal;

  // run_q keeps the request low in the cycle right after reset, so a stray ack there is ignored
  always_comb begin
    imem_req = 1'b0;
    if (run_q) begin
      if (state_q == S_WAIT)                           imem_req = 1'b1;
      else if (state_q == S_FETCH && cnt_q < 2'd2)     imem_req = 1'b1;
    end
  end

  assign imem_addr = (state_q == S_WAIT) ? addr_q : pc_q;
  assign pop       = if_valid && if_ready;
  assign accept    = imem_req && imem_ack;
  assign push      = accept && !disc_q && !br_taken;
  assign wr_hi     = pop ? (cnt_q == 2'd2) : (cnt_q == 2'd1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    disc_d  = disc_q;
    run_d   = 1'b1;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    qpc_d   = qpc_q;

    if (state_q == S_FETCH && imem_req && !imem_ack) addr_d = pc_q;

    if (br_taken) begin
      cnt_d = 2'd0;
      pc_d  = br_target;
      // a request still in flight must complete, but its data belongs to the old path
      if (imem_req && !imem_ack) begin
        state_d = S_WAIT;
        disc_d  = 1'b1;
      end else begin
        state_d = S_FETCH;
        disc_d  = 1'b0;
      end
    end else begin
      if (pop) begin
        instr_d[0] = instr_q[1];
        qpc_d[0]   = qpc_q[1];
      end
      if (push) begin
        if (wr_hi) begin
          instr_d[1] = imem_rdata;
          qpc_d[1]   = pc_q;
        end else begin
          instr_d[0] = imem_rdata;
          qpc_d[0]   = pc_q;
        end
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

      if (accept) begin
        disc_d = 1'b0;
        if (disc_q) begin
          state_d = S_FETCH;
        end else begin
          pc_d    = pc_q + AW'(1);
          state_d = (imem_rdata[15:12] == 4'hF) ? S_HALT : S_FETCH;
        end
      end else if (imem_req) begin
        state_d = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      disc_q     <= 1'b0;
      run_q      <= 1'b0;
      cnt_q      <= 2'd0;
      instr_q[0] <= 16'h0000;
      instr_q[1] <= 16'h0000;
      qpc_q[0]   <= RESET_PC;
      qpc_q[1]   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      disc_q  <= disc_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      qpc_q   <= qpc_d;
    end
  end

endmodule
